mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage of the 5-stage pipeline. It turns the single-cycle MemRead/MemWrite controls leaving the EX/MEM register into a request/ready handshake with a variable-latency data memory. While an access is outstanding it stalls the pipeline, freezing PC, IF/ID, ID/EX and EX/MEM. It then returns read data in the cycle the pipeline advances, and provides a timeout/error indication and a stall performance counter.

---
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns MemRead/MemWrite into a req/ready handshake,
// stalling the pipeline while the data memory access is outstanding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_rdata,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             mem_rdata_valid,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d;
  logic req_q, req_d;
  logic we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic stall_raw;
  logic req_in;

  assign req_in = MemRead | MemWrite;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          stall_raw = 1'b1;
          addr_d    = addr;
          wdata_d   = wdata;
          we_d      = MemWrite & ~MemRead;
          illegal_d = MemRead & MemWrite;
          req_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        stall_raw = 1'b1;
        if (dmem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          valid_d = ~we_q;
          err_d   = illegal_q;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (cnt_q == TLAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // controls still belong to the finished instruction here
        illegal_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = stall_raw & ~reset;

  always_comb begin
    scnt_d = scnt_q;
    if (stall && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      scnt_q    <= scnt_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign mem_rdata       = rdata_q;
  assign mem_rdata_valid = valid_q;
  assign mem_err         = err_q;
  assign stall_count     = scnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4, CNT_W=4).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, mem_rdata;
  logic        mem_rdata_valid, mem_err;
  logic [3:0]  stall_count;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemRead = 1'b1;
    MemWrite = 1'b0;
    dmem_ready = 1'b0;
    #1 chk("rst_stall", {31'b0, stall}, 0);
    step();
    MemRead = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_we", {31'b0, dmem_we}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_valid", {31'b0, mem_rdata_valid}, 0);
    chk("rst_err", {31'b0, mem_err}, 0);
    chk("rst_cnt", {28'b0, stall_count}, 0);
  endtask

  // starts at an IDLE negedge, ends at the DONE negedge
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ready_at, input logic [31:0] rdat,
                        input logic exp_we, input logic exp_valid,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_cnt);
    MemRead = rd;
    MemWrite = wr;
    addr = a;
    wdata = wd;
    #1 chk("idle_stall", {31'b0, stall}, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      addr = 32'hFFFF_FFFF;
      wdata = 32'hEEEE_EEEE;
      #1;
      chk("acc_stall", {31'b0, stall}, 1);
      chk("acc_req", {31'b0, dmem_req}, 1);
      chk("acc_we", {31'b0, dmem_we}, {31'b0, exp_we});
      chk("acc_addr", dmem_addr, a);
      chk("acc_wdata", dmem_wdata, wd);
      if (i == ready_at) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdat;
      end
      if (i == ready_at || i == 4) break;
    end
    step();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h7777_7777;
    #1;
    chk("done_stall", {31'b0, stall}, 0);
    chk("done_req", {31'b0, dmem_req}, 0);
    chk("done_valid", {31'b0, mem_rdata_valid}, {31'b0, exp_valid});
    chk("done_err", {31'b0, mem_err}, {31'b0, exp_err});
    chk("done_rdata", mem_rdata, exp_rdata);
    chk("done_cnt", {28'b0, stall_count}, {28'b0, exp_cnt});
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    addr = '0;
    wdata = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    @(negedge clk);
    do_reset();

    access(1, 0, 32'h100, 32'h0, 1, 32'hCAFEF00D,
           0, 1, 0, 32'hCAFEF00D, 4'd2);
    step();
    #1 chk("idle_after_valid", {31'b0, mem_rdata_valid}, 0);
    chk("idle_after_stall", {31'b0, stall}, 0);

    do_reset();
    access(0, 1, 32'h40, 32'h12345678, 3, 32'hDEADBEEF,
           1, 0, 0, 32'h0, 4'd4);
    step();

    do_reset();
    access(1, 0, 32'h200, 32'h0, 1, 32'h11112222,
           0, 1, 0, 32'h11112222, 4'd2);
    step();
    access(0, 1, 32'h204, 32'hA5A5A5A5, 1, 32'h99999999,
           1, 0, 0, 32'h11112222, 4'd4);
    step();

    access(1, 0, 32'h300, 32'h0, 0, 32'h0,
           0, 0, 1, 32'h0, 4'd9);
    step();
    access(1, 0, 32'h304, 32'h0, 4, 32'h0BADCAFE,
           0, 1, 0, 32'h0BADCAFE, 4'd14);
    step();

    do_reset();
    access(1, 1, 32'h500, 32'h31415926, 1, 32'h55AA55AA,
           0, 1, 1, 32'h55AA55AA, 4'd2);
    step();
    #1 chk("illegal_clear", {31'b0, mem_err}, 0);

    do_reset();
    MemRead = 1'b1;
    addr = 32'h400;
    step();
    step();
    #1 chk("mid_req", {31'b0, dmem_req}, 1);
    reset = 1'b1;
    MemRead = 1'b0;
    #1 chk("mid_rst_stall", {31'b0, stall}, 0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_req", {31'b0, dmem_req}, 0);
    chk("abort_stall", {31'b0, stall}, 0);
    chk("abort_cnt", {28'b0, stall_count}, 0);
    step();
    #1;
    chk("abort_nodone_err", {31'b0, mem_err}, 0);
    chk("abort_nodone_req", {31'b0, dmem_req}, 0);

    access(1, 0, 32'h600, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 4'd5);
    step();
    access(1, 0, 32'h604, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 4'd10);
    step();
    access(1, 0, 32'h608, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 4'd15);
    step();
    access(1, 0, 32'h60C, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 4'd15);
    step();
    #1 chk("sat_hold", {28'b0, stall_count}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
